// File: rtl/uart_param_framer.sv
// Recovers sync/payload/XOR-checksum parameter records from a UART byte stream
// and publishes each accepted payload atomically with a one-cycle valid strobe.
module uart_param_framer #(
    parameter int unsigned PARAM_BYTES    = 26,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_data_i,
    input  logic                       rx_valid_i,
    output logic [8*PARAM_BYTES-1:0]   params_o,
    output logic                       params_valid_o,
    output logic                       busy_o,
    output logic                       err_checksum_o,
    output logic                       err_timeout_o,
    output logic [15:0]                frame_count_o
);

    localparam int unsigned IDX_W = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PARAM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t                     state_q;
    logic [8*PARAM_BYTES-1:0]   shadow_q;
    logic [8*PARAM_BYTES-1:0]   params_q;
    logic [IDX_W-1:0]           idx_q;
    logic [7:0]                 xor_q;
    logic [TMR_W-1:0]           tmr_q;
    logic                       params_valid_q;
    logic                       busy_q;
    logic                       err_checksum_q;
    logic                       err_timeout_q;
    logic [15:0]                frame_count_q;

    // Frame FSM: timer, shadow capture, checksum verdict and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '0;
            params_q       <= '0;
            idx_q          <= '0;
            xor_q          <= 8'h00;
            tmr_q          <= '0;
            params_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            frame_count_q  <= 16'h0000;
        end else begin
            params_valid_q <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            // An idle cycle inside a frame only advances the inter-byte timer;
            // a byte arriving on the expiry cycle takes the normal path below.
            if ((state_q != ST_IDLE) && !rx_valid_i) begin
                if (tmr_q == TMR_LAST) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    tmr_q         <= '0;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
            end else if (rx_valid_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data_i == SYNC_BYTE) begin
                            state_q <= ST_PAYLOAD;
                            idx_q   <= IDX_LAST;
                            xor_q   <= 8'h00;
                            tmr_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow_q[{idx_q, 3'b000} +: 8] <= rx_data_i;
                        xor_q <= xor_q ^ rx_data_i;
                        tmr_q <= '0;
                        if (idx_q == '0) begin
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (rx_data_i == xor_q) begin
                            params_q       <= shadow_q;
                            params_valid_q <= 1'b1;
                            frame_count_q  <= frame_count_q + 16'd1;
                        end else begin
                            err_checksum_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else begin
                tmr_q <= '0;
            end
        end
    end

    assign params_o       = params_q;
    assign params_valid_o = params_valid_q;
    assign busy_o         = busy_q;
    assign err_checksum_o = err_checksum_q;
    assign err_timeout_o  = err_timeout_q;
    assign frame_count_o  = frame_count_q;

endmodule
